// File: rtl/textram_arbiter.sv
// Single-port text RAM arbiter: display reads win, then clear-screen fill, then buffered host writes.
// Optional sticky FIFO overflow flag is built when TEXTRAM_ARB_OVF_EN is defined.
module textram_arbiter #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic        CLK_108MHz,
    input  logic        reset,
    input  logic [15:0] disp_addr,
    input  logic        disp_req,
    input  logic        host_wr_valid,
    input  logic [15:0] host_wr_addr,
    input  logic [7:0]  host_wr_data,
    output logic        host_wr_ready,
    input  logic        clear_req,
    input  logic [7:0]  max_rows,
    input  logic [7:0]  max_columns,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    output logic        clearing,
    output logic        clear_done,
    output logic        fifo_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} sq_state_t;

    sq_state_t     state, state_nxt;
    logic [15:0]   limit, clr_ptr, clear_len;
    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, grant_clear, start_clear;

    logic [15:0]   ram_addr_nxt;
    logic          ram_we_nxt;
    logic [7:0]    ram_wdata_nxt;
    logic          clearing_nxt, clear_done_nxt;

    assign clear_len     = {8'd0, max_rows} * {8'd0, max_columns};
    assign full          = (count == CW'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign host_wr_ready = !full;
    assign push          = host_wr_valid && !full;
    assign grant_clear   = !disp_req && (state == S_CLEAR);
    assign pop           = !disp_req && (state == S_IDLE) && !empty;
    assign start_clear   = (state == S_IDLE) && clear_req;

    // Sequencer state register, latched clear length and fill pointer
    always_ff @(posedge CLK_108MHz) begin
        if (reset) begin
            state   <= S_IDLE;
            limit   <= '0;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (start_clear) begin
                limit   <= clear_len;
                clr_ptr <= '0;
            end else if (grant_clear) begin
                clr_ptr <= clr_ptr + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clear_req)
                    state_nxt = (clear_len == 16'd0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                if (grant_clear && (clr_ptr == limit - 16'd1))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ram_addr_nxt   = ram_addr;
        ram_we_nxt     = 1'b0;
        ram_wdata_nxt  = ram_wdata;
        clearing_nxt   = (state == S_CLEAR);
        clear_done_nxt = (state == S_DONE);
        if (disp_req) begin
            ram_addr_nxt = disp_addr;
        end else if (grant_clear) begin
            ram_addr_nxt  = clr_ptr;
            ram_we_nxt    = 1'b1;
            ram_wdata_nxt = CLEAR_CHAR;
        end else if (pop) begin
            ram_addr_nxt  = fifo_mem[rd_ptr][23:8];
            ram_we_nxt    = 1'b1;
            ram_wdata_nxt = fifo_mem[rd_ptr][7:0];
        end
    end

    always_ff @(posedge CLK_108MHz) begin
        if (reset) begin
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            clearing   <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            ram_addr   <= ram_addr_nxt;
            ram_we     <= ram_we_nxt;
            ram_wdata  <= ram_wdata_nxt;
            clearing   <= clearing_nxt;
            clear_done <= clear_done_nxt;
        end
    end

    // Host write FIFO; storage needs no reset since count gates every read
    always_ff @(posedge CLK_108MHz) begin
        if (push)
            fifo_mem[wr_ptr] <= {host_wr_addr, host_wr_data};
    end

    always_ff @(posedge CLK_108MHz) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef TEXTRAM_ARB_OVF_EN
    always_ff @(posedge CLK_108MHz) begin
        if (reset)
            fifo_ovf <= 1'b0;
        else if (host_wr_valid && full)
            fifo_ovf <= 1'b1;
    end
`else
    assign fifo_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_textram_arbiter.sv
// Bench for textram_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_textram_arbiter;

    localparam int DEPTH = 8;

    logic        CLK_108MHz = 1'b0;
    logic        reset;
    logic [15:0] disp_addr;
    logic        disp_req;
    logic        host_wr_valid;
    logic [15:0] host_wr_addr;
    logic [7:0]  host_wr_data;
    logic        host_wr_ready;
    logic        clear_req;
    logic [7:0]  max_rows;
    logic [7:0]  max_columns;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic        clearing;
    logic        clear_done;
    logic        fifo_ovf;

    textram_arbiter #(.FIFO_DEPTH(DEPTH), .CLEAR_CHAR(8'h20)) dut (
        .CLK_108MHz   (CLK_108MHz),
        .reset        (reset),
        .disp_addr    (disp_addr),
        .disp_req     (disp_req),
        .host_wr_valid(host_wr_valid),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_wr_ready(host_wr_ready),
        .clear_req    (clear_req),
        .max_rows     (max_rows),
        .max_columns  (max_columns),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .clearing     (clearing),
        .clear_done   (clear_done),
        .fifo_ovf     (fifo_ovf)
    );

    always #5 CLK_108MHz = ~CLK_108MHz;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending host writes in a queue, clear as a remaining-address walk
    logic [23:0] m_q[$];
    bit          m_busy, m_done;
    int          m_limit, m_ptr;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wdata;
    bit          e_clearing, e_done, e_ovf;
    int          writes_seen, dones_seen;

    task automatic model_edge();
        bit idle, ready_pre, new_done;
        if (reset) begin
            m_q.delete();
            m_busy = 0; m_done = 0; m_limit = 0; m_ptr = 0;
            e_addr = '0; e_we = 0; e_wdata = '0;
            e_clearing = 0; e_done = 0; e_ovf = 0;
            return;
        end
        idle       = !m_busy && !m_done;
        ready_pre  = m_q.size() < DEPTH;
        e_clearing = m_busy;
        e_done     = m_done;
        new_done   = 0;
        e_we       = 0;
        if (disp_req) begin
            e_addr = disp_addr;
        end else if (m_busy) begin
            e_addr  = 16'(m_ptr);
            e_we    = 1;
            e_wdata = 8'h20;
            m_ptr++;
            if (m_ptr == m_limit) begin
                m_busy   = 0;
                new_done = 1;
            end
        end else if (idle && m_q.size() > 0) begin
            {e_addr, e_wdata} = m_q.pop_front();
            e_we = 1;
        end
        if (idle && clear_req) begin
            m_limit = int'(max_rows) * int'(max_columns);
            m_ptr   = 0;
            if (m_limit == 0) new_done = 1;
            else              m_busy   = 1;
        end
        m_done = new_done;
        if (host_wr_valid && ready_pre)
            m_q.push_back({host_wr_addr, host_wr_data});
`ifdef TEXTRAM_ARB_OVF_EN
        if (host_wr_valid && !ready_pre)
            e_ovf = 1;
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK_108MHz);
        #1;
        check("ram_addr", 32'(ram_addr), 32'(e_addr));
        check("ram_we", 32'(ram_we), 32'(e_we));
        if (e_we)
            check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        check("clearing", 32'(clearing), 32'(e_clearing));
        check("clear_done", 32'(clear_done), 32'(e_done));
        check("fifo_ovf", 32'(fifo_ovf), 32'(e_ovf));
        check("host_wr_ready", 32'(host_wr_ready), 32'(m_q.size() < DEPTH));
        if (ram_we) writes_seen++;
        if (clear_done) dones_seen++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_clear(input logic [7:0] rows, input logic [7:0] cols);
        max_rows    = rows;
        max_columns = cols;
        clear_req   = 1;
        cycle();
        clear_req   = 0;
    endtask

    initial begin
        int dens;
        reset = 1; disp_addr = '0; disp_req = 0;
        host_wr_valid = 0; host_wr_addr = '0; host_wr_data = '0;
        clear_req = 0; max_rows = '0; max_columns = '0;
        run(2);
        check("reset_ready", 32'(host_wr_ready), 32'd1);
        reset = 0;
        run(1);

        // Display has absolute priority over a pending host write
        disp_req = 1; disp_addr = 16'h0123;
        host_wr_valid = 1; host_wr_addr = 16'h0005; host_wr_data = 8'h41;
        cycle();
        host_wr_valid = 0;
        run(3);
        check("s1_disp_addr", 32'(ram_addr), 32'h0123);
        disp_req = 0;
        cycle();
        check("s1_host_addr", 32'(ram_addr), 32'h0005);
        check("s1_host_data", 32'(ram_wdata), 32'h41);
        run(2);

        // Uninterrupted 2x3 clear
        writes_seen = 0; dones_seen = 0;
        pulse_clear(8'd2, 8'd3);
        run(10);
        check("s2_writes", 32'(writes_seen), 32'd6);
        check("s2_dones", 32'(dones_seen), 32'd1);

        // 2x3 clear paused by four display cycles
        writes_seen = 0; dones_seen = 0;
        pulse_clear(8'd2, 8'd3);
        run(2);
        disp_req = 1; disp_addr = 16'h0777;
        run(4);
        disp_req = 0;
        run(10);
        check("s3_writes", 32'(writes_seen), 32'd6);
        check("s3_dones", 32'(dones_seen), 32'd1);

        // Nine back-to-back writes into an 8-deep FIFO while the display holds the RAM
        disp_req = 1;
        for (int i = 0; i < 9; i++) begin
            host_wr_valid = 1;
            host_wr_addr  = 16'h0100 + 16'(i);
            host_wr_data  = 8'(i + 1);
            cycle();
        end
        host_wr_valid = 0;
        check("s4_ready_low", 32'(host_wr_ready), 32'd0);
        writes_seen = 0;
        disp_req = 0;
        run(10);
        check("s4_drained", 32'(writes_seen), 32'd8);

        // Zero-size clear: done only, no writes
        writes_seen = 0; dones_seen = 0;
        pulse_clear(8'd0, 8'd7);
        run(4);
        check("s5_writes", 32'(writes_seen), 32'd0);
        check("s5_dones", 32'(dones_seen), 32'd1);

        // Reset during a long clear with writes queued
        pulse_clear(8'd10, 8'd10);
        run(2);
        for (int i = 0; i < 3; i++) begin
            host_wr_valid = 1;
            host_wr_addr  = 16'h0200 + 16'(i);
            host_wr_data  = 8'hA0 + 8'(i);
            cycle();
        end
        host_wr_valid = 0;
        reset = 1;
        cycle();
        reset = 0;
        writes_seen = 0; dones_seen = 0;
        run(20);
        check("s6_writes", 32'(writes_seen), 32'd0);
        check("s6_dones", 32'(dones_seen), 32'd0);

        // Randomized traffic with varying display density
        for (int blk = 0; blk < 8; blk++) begin
            dens = $urandom_range(20, 95);
            for (int c = 0; c < 400; c++) begin
                reset         = ($urandom_range(0, 599) == 0);
                disp_req      = ($urandom_range(0, 99) < dens);
                disp_addr     = 16'($urandom);
                host_wr_valid = ($urandom_range(0, 2) == 0);
                host_wr_addr  = 16'($urandom);
                host_wr_data  = 8'($urandom);
                clear_req     = ($urandom_range(0, 49) == 0);
                max_rows      = 8'($urandom_range(0, 5));
                max_columns   = 8'($urandom_range(0, 5));
                cycle();
            end
        end
        reset = 0; disp_req = 0; host_wr_valid = 0; clear_req = 0;
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/textram_arbiter.md
Name: textram_arbiter

Overview:
- Single-port arbiter for the character text RAM shared by the display read path and a host writer.
- The display read path is the address from the dot-address stage, qualified by data enable.
- Host writes (UART/CPU) are buffered in a small FIFO and issued only in cycles the display does not need.
- Contains a clear-screen sequencer that fills the visible area (max_rows x max_columns) with a fill character.
- Sits between the dot-address stage and the text RAM.

Parameters:
- FIFO_DEPTH, 8, host write FIFO entries; power of two, 2..64.
- CLEAR_CHAR, 8'h20, byte written to every location by a clear.

Ports:
- CLK_108MHz  input  1  global clock
- reset  input  1  synchronous reset, active-high
- disp_addr  input  16  display read address
- disp_req  input  1  display read needed this cycle (registered data enable)
- host_wr_valid  input  1  host write request
- host_wr_addr  input  16  host write address
- host_wr_data  input  8  host write data
- host_wr_ready  output  1  FIFO can accept a write
- clear_req  input  1  single-cycle pulse, start clear-screen
- max_rows  input  8  visible text rows
- max_columns  input  8  visible text columns
- ram_addr  output  16  text RAM address
- ram_we  output  1  text RAM write enable
- ram_wdata  output  8  text RAM write data
- clearing  output  1  clear sequence in progress
- clear_done  output  1  one-cycle pulse when clear completes
- fifo_ovf  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- All outputs are registered. Reset is synchronous, active-high, sampled on the CLK_108MHz rising edge.
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, clearing=0, clear_done=0, fifo_ovf=0. FIFO is emptied, so host_wr_ready=1 in the cycle after reset deasserts.
- Reset mid-clear or mid-drain abandons the operation. Queued writes are lost.
- Priority each cycle, with the result visible on the RAM outputs the next cycle (1-cycle latency):
  1. disp_req=1: ram_addr=disp_addr, ram_we=0. Display is never stalled or delayed.
  2. Otherwise, state CLEAR: ram_addr=clr_ptr, ram_we=1, ram_wdata=CLEAR_CHAR; clr_ptr increments.
  3. Otherwise, state IDLE and FIFO non-empty: pop the head; ram_addr/ram_wdata = entry, ram_we=1.
  4. Otherwise: ram_we=0, ram_addr holds its last value.
- FIFO:
  - host_wr_ready = !full.
  - Push on host_wr_valid && host_wr_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - No bypass: a write accepted in cycle N reaches the RAM no earlier than cycle N+2.
  - Writes are issued in acceptance order.
- Sequencer states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clear_req. In that cycle, latch limit = max_rows*max_columns (8x8 -> 16-bit unsigned product, no truncation) and set clr_ptr=0.
  - If limit=0: IDLE -> DONE directly; no RAM writes.
  - CLEAR -> DONE once the write of address limit-1 is issued. clr_ptr advances only on granted cycles, so display cycles pause the clear.
  - DONE -> IDLE after one cycle. clear_done=1 for exactly that cycle.
  - clearing=1 in CLEAR.
  - clear_req while in CLEAR or DONE is ignored.
  - max_rows/max_columns changes during CLEAR have no effect; the latched limit is used.
- Host writes are still accepted during CLEAR but are not drained until IDLE. Writes queued during a clear therefore land after it.
- Maximum clear length is 65025 writes; clr_ptr never wraps.

Optional Feature:
- Macro: TEXTRAM_ARB_OVF_EN.
- Defined: fifo_ovf sets when host_wr_valid=1 while host_wr_ready=0. It stays set until reset. The write is dropped.
- Undefined: fifo_ovf is tied 0 and no overflow logic is built.
- Arbitration is identical either way.

Test Plan:
- disp_req held 1, disp_addr=16'h0123, host write pending -> next cycle ram_addr=16'h0123, ram_we=0. No host write is issued while disp_req=1. Host write (addr 16'h0005, data 8'h41) is issued the first cycle after disp_req=0.
- max_rows=2, max_columns=3, clear_req pulse, disp_req=0 -> ram_we=1 for addresses 0..5 with data 8'h20 on 6 consecutive cycles, then clear_done pulses once and clearing falls.
- Same clear with disp_req=1 for 4 cycles mid-sequence -> still exactly 6 writes to 0..5 with none skipped. clear_done is delayed by 4 cycles.
- 9 back-to-back host writes with disp_req=1, FIFO_DEPTH=8 -> host_wr_ready low after 8 accepts. With TEXTRAM_ARB_OVF_EN, fifo_ovf=1. After disp_req=0, 8 writes drain in order.
- max_rows=0, clear_req -> no RAM writes; clear_done pulses 2 cycles after clear_req.
- Reset asserted mid-clear with 3 writes queued -> next cycle all outputs reset. The FIFO is empty, no further writes occur, and host_wr_ready=1 after reset deasserts.
